// File: rtl/multi_port_memory_if.sv
// ---------------------------------------------------------------------------
// multi_port_memory_if
// Bus bundle for multi_port_memory: one write port and READ_PORTS read ports.
//   write_in / write_address_in / write_data_in / write_mode_in : write request
//   read_en_in / read_address_in / read_mode_in / read_unsigned_in : per-port
//     read requests, port p in the p-th slice of each packed vector
//   read_data_out / read_valid_out / read_error_out : per-port registered
//     read results
//   write_error_out : rejected-write pulse
//   ready_out       : memory accepts accesses
// Modports: master (requester side), slave (memory side).
// ---------------------------------------------------------------------------
interface multi_port_memory_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_PORTS    = 2
);
  logic                            write_in;
  logic [ADDRESS_WIDTH-1:0]        write_address_in;
  logic [31:0]                     write_data_in;
  logic [1:0]                      write_mode_in;
  logic [READ_PORTS-1:0]           read_en_in;
  logic [READ_PORTS*ADDRESS_WIDTH-1:0] read_address_in;
  logic [2*READ_PORTS-1:0]         read_mode_in;
  logic [READ_PORTS-1:0]           read_unsigned_in;
  logic [32*READ_PORTS-1:0]        read_data_out;
  logic [READ_PORTS-1:0]           read_valid_out;
  logic [READ_PORTS-1:0]           read_error_out;
  logic                            write_error_out;
  logic                            ready_out;

  modport master (
    output write_in, write_address_in, write_data_in, write_mode_in,
    output read_en_in, read_address_in, read_mode_in, read_unsigned_in,
    input  read_data_out, read_valid_out, read_error_out,
    input  write_error_out, ready_out
  );

  modport slave (
    input  write_in, write_address_in, write_data_in, write_mode_in,
    input  read_en_in, read_address_in, read_mode_in, read_unsigned_in,
    output read_data_out, read_valid_out, read_error_out,
    output write_error_out, ready_out
  );
endinterface

// File: rtl/multi_port_memory.sv
// ---------------------------------------------------------------------------
// multi_port_memory
// Byte-addressable, little-endian 32-bit-word memory with one write port and
// READ_PORTS independent 1-cycle-latency read ports. Word/half/byte accesses;
// misaligned or reserved-mode accesses are rejected and flagged.
//
// Ports:
//   clock_in    : sole clock, rising edge
//   reset_n_in  : asynchronous active-low reset
//   bus         : multi_port_memory_if.slave (write port, read ports, status)
//
// Configuration macro:
//   MULTI_PORT_MEMORY_INIT_CLEAR_EN - when defined, the INIT state sweeps the
//   array to zero one word per cycle before READY. When undefined, READY is
//   entered on the first edge after reset and contents are not initialised.
// ---------------------------------------------------------------------------
module multi_port_memory #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_PORTS    = 2
) (
  input  logic clock_in,
  input  logic reset_n_in,
  multi_port_memory_if.slave bus
);

  localparam int WORD_AW = ADDRESS_WIDTH - 2;
  localparam int WORDS   = 2 ** WORD_AW;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b10;
  localparam logic [1:0] MODE_BYTE = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Reserved mode or an address not aligned to the access size.
  function automatic logic access_bad(input logic [1:0] mode, input logic [1:0] lo);
    logic bad;
    case (mode)
      MODE_WORD: bad = (lo != 2'b00);
      MODE_HALF: bad = lo[0];
      MODE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte lanes touched by an access of the given size at lane offset lo.
  function automatic logic [3:0] lane_mask(input logic [1:0] mode, input logic [1:0] lo);
    logic [3:0] m;
    case (mode)
      MODE_WORD: m = 4'b1111;
      MODE_HALF: m = 4'b0011 << lo;
      MODE_BYTE: m = 4'b0001 << lo;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate right-aligned write data so every candidate lane carries it.
  function automatic logic [31:0] lane_data(input logic [1:0] mode, input logic [31:0] d);
    logic [31:0] r;
    case (mode)
      MODE_HALF: r = {2{d[15:0]}};
      MODE_BYTE: r = {4{d[7:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Right-align the addressed half/byte and sign- or zero-extend it.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] mode,
                                          input logic [1:0] lo, input logic uns);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = lo[1] ? word[31:16] : word[15:0];
    b = word[{lo, 3'b000} +: 8];
    case (mode)
      MODE_WORD: r = word;
      MODE_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      MODE_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t r_state;
  state_t w_state_next;
  logic   w_ready;

`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
  logic [WORD_AW-1:0] r_clr_ptr;
  logic [WORD_AW-1:0] w_clr_ptr_next;
`endif

  logic [31:0] r_mem [WORDS];

  logic               w_wr_bad;
  logic               w_wr_ok;
  logic               w_wr_err;
  logic [WORD_AW-1:0] w_wr_word;
  logic [31:0]        w_wr_bitmask;
  logic [31:0]        w_wr_lanes;
  logic [31:0]        w_wr_merged;

  logic [31:0]           w_rd_word [READ_PORTS];
  logic [31:0]           w_rd_data [READ_PORTS];
  logic [READ_PORTS-1:0] w_rd_bad;

  logic [32*READ_PORTS-1:0] r_rd_data;
  logic [READ_PORTS-1:0]    r_rd_valid;
  logic [READ_PORTS-1:0]    r_rd_err;
  logic                     r_wr_err;

  assign w_ready = (r_state == ST_READY);

  // Controller state and clear pointer register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state   <= ST_INIT;
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
      r_clr_ptr <= {WORD_AW{1'b0}};
`endif
    end else begin
      r_state   <= w_state_next;
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
      r_clr_ptr <= w_clr_ptr_next;
`endif
    end
  end

  // Next-state logic: INIT sweeps (or skips) the clear, READY is terminal.
  always_comb begin
    w_state_next   = r_state;
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
    w_clr_ptr_next = r_clr_ptr;
`endif
    case (r_state)
      ST_INIT: begin
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
        w_clr_ptr_next = r_clr_ptr + WORD_AW'(1);
        // The edge that clears the last word is the one that enters READY.
        if (&r_clr_ptr) begin
          w_state_next = ST_READY;
        end else begin
          w_state_next = ST_INIT;
        end
`else
        w_state_next = ST_READY;
`endif
      end
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_INIT;
    endcase
  end

  // Write decode: lane mask, lane data and the merged post-write word.
  always_comb begin
    w_wr_word    = bus.write_address_in[ADDRESS_WIDTH-1:2];
    w_wr_bad     = access_bad(bus.write_mode_in, bus.write_address_in[1:0]);
    w_wr_ok      = w_ready & bus.write_in & ~w_wr_bad;
    w_wr_err     = w_ready & bus.write_in & w_wr_bad;
    w_wr_bitmask = expand_mask(lane_mask(bus.write_mode_in, bus.write_address_in[1:0]));
    w_wr_lanes   = lane_data(bus.write_mode_in, bus.write_data_in);
    w_wr_merged  = (r_mem[w_wr_word] & ~w_wr_bitmask) | (w_wr_lanes & w_wr_bitmask);
  end

  // Storage array: zero sweep during INIT, lane-merged writes in READY.
  always_ff @(posedge clock_in) begin
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
    if (r_state == ST_INIT) begin
      r_mem[r_clr_ptr] <= 32'h0000_0000;
    end else if (w_wr_ok) begin
      r_mem[w_wr_word] <= w_wr_merged;
    end
`else
    if (w_wr_ok) begin
      r_mem[w_wr_word] <= w_wr_merged;
    end
`endif
  end

  // Per-port read path; a same-edge write to the same word is forwarded.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      if (w_wr_ok && (bus.read_address_in[p*ADDRESS_WIDTH+2 +: WORD_AW] == w_wr_word)) begin
        w_rd_word[p] = w_wr_merged;
      end else begin
        w_rd_word[p] = r_mem[bus.read_address_in[p*ADDRESS_WIDTH+2 +: WORD_AW]];
      end
      w_rd_bad[p]  = access_bad(bus.read_mode_in[2*p +: 2],
                                bus.read_address_in[p*ADDRESS_WIDTH +: 2]);
      w_rd_data[p] = extract(w_rd_word[p], bus.read_mode_in[2*p +: 2],
                             bus.read_address_in[p*ADDRESS_WIDTH +: 2],
                             bus.read_unsigned_in[p]);
    end
  end

  // Registered read results and write-error pulse.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rd_data  <= {(32*READ_PORTS){1'b0}};
      r_rd_valid <= {READ_PORTS{1'b0}};
      r_rd_err   <= {READ_PORTS{1'b0}};
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err <= w_wr_err;
      for (int p = 0; p < READ_PORTS; p++) begin
        if (w_ready && bus.read_en_in[p]) begin
          if (w_rd_bad[p]) begin
            r_rd_data[32*p +: 32] <= 32'h0000_0000;
            r_rd_valid[p]         <= 1'b0;
            r_rd_err[p]           <= 1'b1;
          end else begin
            r_rd_data[32*p +: 32] <= w_rd_data[p];
            r_rd_valid[p]         <= 1'b1;
            r_rd_err[p]           <= 1'b0;
          end
        end else begin
          // Idle port keeps its last data; status flags drop.
          r_rd_valid[p] <= 1'b0;
          r_rd_err[p]   <= 1'b0;
        end
      end
    end
  end

  assign bus.read_data_out   = r_rd_data;
  assign bus.read_valid_out  = r_rd_valid;
  assign bus.read_error_out  = r_rd_err;
  assign bus.write_error_out = r_wr_err;
  assign bus.ready_out       = w_ready;

endmodule

// File: tb/tb_multi_port_memory.sv
// ---------------------------------------------------------------------------
// tb_multi_port_memory
// Self-checking bench for multi_port_memory (ADDRESS_WIDTH=8, READ_PORTS=2).
// A byte-level reference model predicts every cycle's outputs; a directed
// vector table, reset sequences and a randomized phase drive the design.
// ---------------------------------------------------------------------------
module tb_multi_port_memory;
  localparam int AW = 8;
  localparam int RP = 2;
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
  localparam int INIT_CYCLES = 64;
  localparam bit CLEARS      = 1'b1;
`else
  localparam int INIT_CYCLES = 1;
  localparam bit CLEARS      = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multi_port_memory_if #(.ADDRESS_WIDTH(AW), .READ_PORTS(RP)) bus ();

  multi_port_memory #(.ADDRESS_WIDTH(AW), .READ_PORTS(RP)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: byte array with a "value known" flag per byte.
  byte unsigned m_mem   [256];
  bit           m_known [256];
  bit           m_ready;
  int           m_init_left;
  logic [31:0]  e_data   [RP];
  bit           e_dknown [RP];
  logic [RP-1:0] e_valid, e_err;
  logic          e_werr;

  typedef struct {
    logic        we;  logic [7:0] wa;  logic [31:0] wd;  logic [1:0] wm;
    logic [1:0]  ren; logic [7:0] ra0; logic [7:0] ra1;
    logic [1:0]  rm0; logic [1:0] rm1; logic [1:0] ru;
    logic        ewe; logic [1:0] ev;  logic [1:0] ee;
    logic [31:0] ed0; logic [31:0] ed1; logic [1:0] chk;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [1:0] m);
    case (m)
      2'b00:   return 4;
      2'b10:   return 2;
      2'b11:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_bad(input logic [1:0] m, input int a);
    int sz;
    sz = size_of(m);
    return (sz == 0) || ((a % sz) != 0);
  endfunction

  task automatic model_reset();
    m_ready     = 1'b0;
    m_init_left = INIT_CYCLES;
    e_werr      = 1'b0;
    e_valid     = 2'b00;
    e_err       = 2'b00;
    for (int p = 0; p < RP; p++) begin
      e_data[p]   = 32'h0;
      e_dknown[p] = 1'b1;
    end
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = CLEARS;
    end
  endtask

  // Predict the outputs that follow the coming rising edge.
  task automatic model_edge();
    int a, sz;
    logic [31:0] val;
    bit kn;
    e_werr  = 1'b0;
    e_valid = 2'b00;
    e_err   = 2'b00;
    if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1'b1;
      return;
    end
    if (bus.write_in) begin
      a  = int'(bus.write_address_in);
      sz = size_of(bus.write_mode_in);
      if (is_bad(bus.write_mode_in, a)) begin
        e_werr = 1'b1;
      end else begin
        for (int i = 0; i < sz; i++) begin
          m_mem[a+i]   = bus.write_data_in[8*i +: 8];
          m_known[a+i] = 1'b1;
        end
      end
    end
    for (int p = 0; p < RP; p++) begin
      if (bus.read_en_in[p]) begin
        a  = int'(bus.read_address_in[p*AW +: AW]);
        sz = size_of(bus.read_mode_in[2*p +: 2]);
        if (is_bad(bus.read_mode_in[2*p +: 2], a)) begin
          e_data[p]   = 32'h0;
          e_dknown[p] = 1'b1;
          e_err[p]    = 1'b1;
        end else begin
          val = 32'h0;
          kn  = 1'b1;
          for (int i = 0; i < sz; i++) begin
            val = val | (32'(m_mem[a+i]) << (8*i));
            kn  = kn & m_known[a+i];
          end
          if (sz < 4 && !bus.read_unsigned_in[p] && val[8*sz-1])
            val = val | (32'hFFFF_FFFF << (8*sz));
          e_data[p]   = val;
          e_dknown[p] = kn;
          e_valid[p]  = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    check("ready_out", {31'h0, bus.ready_out}, {31'h0, m_ready});
    check("write_error_out", {31'h0, bus.write_error_out}, {31'h0, e_werr});
    check("read_valid_out", {30'h0, bus.read_valid_out}, {30'h0, e_valid});
    check("read_error_out", {30'h0, bus.read_error_out}, {30'h0, e_err});
    for (int p = 0; p < RP; p++)
      if (e_dknown[p])
        check($sformatf("read_data_out[%0d]", p), bus.read_data_out[32*p +: 32], e_data[p]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic set_idle();
    bus.write_in         = 1'b0;
    bus.write_address_in = 8'h00;
    bus.write_data_in    = 32'h0;
    bus.write_mode_in    = 2'b00;
    bus.read_en_in       = 2'b00;
    bus.read_address_in  = 16'h0000;
    bus.read_mode_in     = 4'h0;
    bus.read_unsigned_in = 2'b00;
  endtask

  task automatic rand_inputs();
    logic [7:0] a0;
    bus.write_in         = 1'($urandom_range(0, 1));
    bus.write_address_in = 8'($urandom_range(0, 63));
    bus.write_data_in    = $urandom;
    bus.write_mode_in    = 2'($urandom_range(0, 3));
    bus.read_en_in       = 2'($urandom_range(0, 3));
    a0                   = 8'($urandom_range(0, 63));
    bus.read_address_in[7:0]  = a0;
    bus.read_address_in[15:8] = ($urandom_range(0, 3) == 0) ? a0 : 8'($urandom_range(0, 63));
    bus.read_mode_in     = 4'($urandom_range(0, 15));
    bus.read_unsigned_in = 2'($urandom_range(0, 3));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (3) @(posedge clk);
    #1;
    compare();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit junk);
    int n;
    n = 0;
    while (n < 300) begin
      if (junk) rand_inputs();
      else set_idle();
      tick();
      n++;
      if (bus.ready_out) break;
    end
    check("init_cycles", 32'(n), 32'(INIT_CYCLES));
    set_idle();
  endtask

  task automatic apply_vec(input vec_t v);
    bus.write_in         = v.we;
    bus.write_address_in = v.wa;
    bus.write_data_in    = v.wd;
    bus.write_mode_in    = v.wm;
    bus.read_en_in       = v.ren;
    bus.read_address_in  = {v.ra1, v.ra0};
    bus.read_mode_in     = {v.rm1, v.rm0};
    bus.read_unsigned_in = v.ru;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             we   wa     wd            wm     ren    ra0    ra1    rm0    rm1    ru     ewe  ev     ee     ed0           ed1           chk
    tbl[0]  = '{1'b1, 8'h00, 32'h0000_0001, 2'b00, 2'b01, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 32'h0000_0001, 32'h0,        2'b01};
    tbl[1]  = '{1'b1, 8'h1C, 32'h0000_00AB, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0000_0001, 32'h0,        2'b01};
    tbl[2]  = '{1'b1, 8'h1D, 32'h0000_00CD, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0000_0001, 32'h0,        2'b01};
    tbl[3]  = '{1'b1, 8'h1E, 32'h0000_00B0, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0000_0001, 32'h0,        2'b01};
    tbl[4]  = '{1'b1, 8'h1F, 32'h0000_001B, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0000_0001, 32'h0,        2'b01};
    tbl[5]  = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b11, 8'h1C, 8'h1E, 2'b00, 2'b11, 2'b00, 1'b0, 2'b11, 2'b00, 32'h1BB0_CDAB, 32'hFFFF_FFB0, 2'b11};
    tbl[6]  = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b11, 8'h1C, 8'h1E, 2'b10, 2'b11, 2'b11, 1'b0, 2'b11, 2'b00, 32'h0000_CDAB, 32'h0000_00B0, 2'b11};
    tbl[7]  = '{1'b1, 8'h18, 32'h1234_5678, 2'b00, 2'b11, 8'h18, 8'h1C, 2'b00, 2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 32'h1234_5678, 32'hFFFF_CDAB, 2'b11};
    tbl[8]  = '{1'b1, 8'h19, 32'h0000_ABCD, 2'b10, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 32'h1234_5678, 32'hFFFF_CDAB, 2'b11};
    tbl[9]  = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b11, 8'h18, 8'h19, 2'b00, 2'b10, 2'b00, 1'b0, 2'b01, 2'b10, 32'h1234_5678, 32'h0,        2'b11};
    tbl[10] = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b11, 8'h1C, 8'h1C, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 32'h1BB0_CDAB, 32'h1BB0_CDAB, 2'b11};
    tbl[11] = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b01, 8'h1C, 8'h1C, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 32'h1BB0_CDAB, 32'h1BB0_CDAB, 2'b11};
    tbl[12] = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b00, 8'h1C, 8'h1C, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 32'h1BB0_CDAB, 32'h1BB0_CDAB, 2'b11};
    tbl[13] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 2'b01, 2'b01, 8'h00, 8'h00, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 32'h0,        32'h1BB0_CDAB, 2'b11};
    tbl[14] = '{1'b0, 8'h00, 32'h0,         2'b00, 2'b01, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 32'h0000_0001, 32'h1BB0_CDAB, 2'b11};
    tbl[15] = '{1'b1, 8'h02, 32'h0000_BEEF, 2'b10, 2'b11, 8'h00, 8'h02, 2'b00, 2'b10, 2'b10, 1'b0, 2'b11, 2'b00, 32'hBEEF_0001, 32'h0000_BEEF, 2'b11};
    tbl[16] = '{1'b1, 8'h05, 32'hFFFF_FFFF, 2'b00, 2'b11, 8'h00, 8'h1E, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b10, 32'hBEEF_0001, 32'h0,        2'b11};

    set_idle();
    apply_reset();
    wait_ready(1'b1);

    // Highest word read on port 1 right after the clear sweep.
    bus.read_en_in = 2'b10;
    bus.read_address_in[15:8] = 8'hFC;
    tick();
    check("fc_valid", {31'h0, bus.read_valid_out[1]}, 32'h1);
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
    check("fc_data", bus.read_data_out[63:32], 32'h0);
`endif
    set_idle();

    for (int i = 0; i < 17; i++) begin
      apply_vec(tbl[i]);
      tick();
      check($sformatf("vec%0d write_error", i), {31'h0, bus.write_error_out}, {31'h0, tbl[i].ewe});
      check($sformatf("vec%0d valid", i), {30'h0, bus.read_valid_out}, {30'h0, tbl[i].ev});
      check($sformatf("vec%0d error", i), {30'h0, bus.read_error_out}, {30'h0, tbl[i].ee});
      if (tbl[i].chk[0]) check($sformatf("vec%0d data0", i), bus.read_data_out[31:0], tbl[i].ed0);
      if (tbl[i].chk[1]) check($sformatf("vec%0d data1", i), bus.read_data_out[63:32], tbl[i].ed1);
    end
    set_idle();
    tick();

    // Reset in the middle of the clear sweep restarts it from the top.
    apply_reset();
    repeat (10) tick();
    apply_reset();
    wait_ready(1'b0);

    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      tick();
    end

    // Reset mid-run after a known write; the word must read back cleared.
    set_idle();
    bus.write_in = 1'b1; bus.write_address_in = 8'h1C;
    bus.write_data_in = 32'hDEAD_BEEF; bus.write_mode_in = 2'b00;
    tick();
    set_idle();
    bus.read_en_in = 2'b01; bus.read_address_in[7:0] = 8'h1C;
    tick();
    set_idle();
    apply_reset();
    wait_ready(1'b0);
    bus.read_en_in = 2'b01; bus.read_address_in[7:0] = 8'h1C;
    tick();
    check("post_reset_valid", {31'h0, bus.read_valid_out[0]}, 32'h1);
`ifdef MULTI_PORT_MEMORY_INIT_CLEAR_EN
    check("post_reset_data", bus.read_data_out[31:0], 32'h0);
`endif
    set_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multi_port_memory.md
MULTI_PORT_MEMORY -- requirements
Module: multi_port_memory

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, byte-address width; capacity 2**ADDRESS_WIDTH bytes, 2**(ADDRESS_WIDTH-2) words.
REQ-002 SHALL have parameter READ_PORTS, default 2, number of independent read ports, range 1..4.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clock_in  input  1  sole clock, all state updates on rising edge.
REQ-005 reset_n_in  input  1  asynchronous active-low reset.
REQ-006 write_in  input  1  write request.
REQ-007 write_address_in  input  ADDRESS_WIDTH  byte address of write.
REQ-008 write_data_in  input  32  write data, right-aligned for half/byte.
REQ-009 write_mode_in  input  2  00 word, 10 half, 11 byte, 01 reserved.
REQ-010 read_en_in  input  READ_PORTS  per-port read request, bit p = port p.
REQ-011 read_address_in  input  READ_PORTS*ADDRESS_WIDTH  packed byte addresses, port p at [p*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-012 read_mode_in  input  2*READ_PORTS  per-port mode, same encoding as write_mode_in.
REQ-013 read_unsigned_in  input  READ_PORTS  1 = zero-extend, 0 = sign-extend half/byte reads.
REQ-014 read_data_out  output  32*READ_PORTS  packed registered read data.
REQ-015 read_valid_out  output  READ_PORTS  per-port data valid.
REQ-016 read_error_out  output  READ_PORTS  per-port misaligned/reserved-mode flag.
REQ-017 write_error_out  output  1  rejected write flag.
REQ-018 ready_out  output  1  high when memory accepts accesses.

Function
REQ-019 Byte order SHALL be little-endian: byte at address A occupies bits [8*(A%4)+:8] of word A>>2.
REQ-020 Controller SHALL have states INIT and READY; reset enters INIT; INIT clears one word per cycle from word 0 upward, entering READY the cycle after the last word is cleared.
REQ-021 ready_out SHALL be 1 only in READY; in INIT, write_in and read_en_in are ignored and all valid/error outputs stay 0.
REQ-022 Write in READY SHALL update only the addressed byte lanes on the rising edge with write_in=1: word all 4, half lanes A%4 and A%4+1, byte lane A%4.
REQ-023 Misaligned write (word with A[1:0]!=0, half with A[0]!=0) or mode 01 SHALL leave memory unchanged and assert write_error_out for exactly one cycle.
REQ-024 Read latency SHALL be 1 cycle: read_en_in[p]=1 at edge N gives read_data_out/read_valid_out[p] valid after edge N, held one cycle.
REQ-025 Half/byte read data SHALL be right-aligned and extended to 32 bits per read_unsigned_in[p].
REQ-026 Misaligned read or mode 01 SHALL return data 0, read_valid_out[p]=0, read_error_out[p]=1 for one cycle.
REQ-027 Read and write to the same word on the same edge SHALL return the post-write contents (write-first) on every port.
REQ-028 With read_en_in[p]=0, read_data_out[p] SHALL hold its last value and read_valid_out[p], read_error_out[p] SHALL be 0.
REQ-029 All read ports SHALL operate concurrently, including identical addresses, without conflict or stall.
REQ-030 Address arithmetic SHALL not wrap: half/byte lanes never cross a word boundary by REQ-023/REQ-026 rules.

Reset
REQ-031 Reset assertion SHALL immediately force read_data_out=0, read_valid_out=0, read_error_out=0, write_error_out=0, ready_out=0, state INIT, clear pointer 0.
REQ-032 Reset asserted mid-INIT or mid-READY SHALL restart the full clear sequence after deassertion.

Configuration
REQ-033 Macro MULTI_PORT_MEMORY_INIT_CLEAR_EN SHALL enable the INIT clear sweep (ready_out high 2**(ADDRESS_WIDTH-2) cycles after reset deassertion).
REQ-034 Without MULTI_PORT_MEMORY_INIT_CLEAR_EN, ready_out SHALL rise on the first edge after reset deassertion and memory contents are not initialised; all other behaviour unchanged.

Verification (ADDRESS_WIDTH=8, READ_PORTS=2, macro defined)
REQ-035 Release reset -> ready_out=0 for 64 cycles then 1; read word 0xFC on port 1 -> 0x00000000, valid=1.
REQ-036 Word write 0x00000001 @0x00, same edge read port 0 @0x00 -> next cycle read_data 0x00000001 (write-first).
REQ-037 Byte writes 0xAB@0x1C, 0xCD@0x1D, 0xB0@0x1E, 0x1B@0x1F -> word read @0x1C = 0x1BB0CDAB; signed byte read @0x1E = 0xFFFFFFB0, unsigned = 0x000000B0.
REQ-038 Half write 0xABCD @0x19 -> write_error_out pulse 1 cycle, word @0x18 unchanged; half read @0x19 -> read_error_out=1, data 0, valid 0.
REQ-039 Both ports read 0x1C while read_en_in toggled 11->01->00 -> port 1 holds last data with valid 0, port 0 valid only while enabled.
REQ-040 Assert reset_n_in mid-run after writes -> outputs 0 at once; after release ready_out low 64 cycles and word @0x1C reads 0x00000000.
